// File: rtl/uart_rx.sv
// uart_rx - 8N1 asynchronous serial receiver.
// Finds the start edge, times the half bit to mid-start itself, then
// enables the external baud generator so its strobe lands mid-bit for
// every data bit and the stop bit. Received bytes are offered on a
// valid/ready port; framing errors and overruns are one-cycle pulses.

module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int HALF_THR  = 521
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 rxd,
   input  logic                 rx_br_stb,
   output logic                 rx_br_en,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   // bit_idx must be able to reach DATA_BITS
   localparam int                 IDX_W     = $clog2(DATA_BITS + 1);
   localparam logic [10:0]        HALF_LAST = 11'(HALF_THR - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state;
   logic                 rxd_m;
   logic                 rxd_s;
   logic                 rxd_d;
   logic                 fall_edge;
   logic [10:0]          half_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;

   // A start edge is a high-to-low step on the synchronised line; a line
   // that is merely held low (break) never produces one.
   assign fall_edge = ~rxd_s & rxd_d;

   // Two-flop synchroniser plus one delay stage for edge detection; idle is high.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         rxd_d <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
         rxd_d <= rxd_s;
      end
   end

   // Frame FSM with registered baud enable, output byte and status pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         half_cnt  <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_br_en  <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // status flags are single-cycle pulses
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // consumer handshake; a frame completing this cycle overrides it below
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               rx_br_en <= 1'b0;
               if (fall_edge) begin
                  state    <= START;
                  half_cnt <= '0;
               end
            end

            START: begin
               // line back high before mid-start means a glitch, not a frame
               if (rxd_s) begin
                  state <= IDLE;
               end else if (half_cnt == HALF_LAST) begin
                  state    <= DATA;
                  rx_br_en <= 1'b1;
                  bit_idx  <= '0;
               end else begin
                  half_cnt <= half_cnt + 11'd1;
               end
            end

            DATA: begin
               if (rx_br_stb) begin
                  shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                  end
               end
            end

            STOP: begin
               if (rx_br_stb) begin
                  // dropping the enable re-zeros the generator for the next frame
                  state    <= IDLE;
                  rx_br_en <= 1'b0;
                  if (rxd_s) begin
                     rx_data  <= shreg;
                     rx_valid <= 1'b1;
                     overrun  <= rx_valid & ~rx_ready;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end

            default: begin
               state    <= IDLE;
               rx_br_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
